// File: rtl/pc_unit.sv
// Program counter with a circular return-address stack for calls and returns.
// Sequences fetch addresses: increment, absolute jump, relative branch, call, return.
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                IMM_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic              br_taken,
    input  logic [IMM_W-1:0]  imm,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              err
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BR   = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] imm_zx;
    logic [ADDR_W-1:0] imm_sx;
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;
    logic              empty_w;
    logic              full_w;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign imm_zx  = ADDR_W'(imm);
    assign imm_sx  = ADDR_W'($signed(imm));
    assign top_inc = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
    assign top_dec = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);
    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        err_d = err_q;
        ras_d = ras_q;
        if (en) begin
            case (op)
                OP_JMP:  pc_d = imm_zx;
                OP_BR:   pc_d = br_taken ? (pc_q + imm_sx) : pc_inc;
                OP_CALL: begin
                    // When full, top_inc lands on the oldest entry, so it is overwritten.
                    ras_d[top_inc] = pc_inc;
                    top_d          = top_inc;
                    pc_d           = imm_zx;
                    if (full_w) err_d = 1'b1;
                    else        cnt_d = cnt_q + CNT_W'(1);
                end
                OP_RET: begin
                    if (empty_w) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d  = ras_q[top_q];
                        top_d = top_dec;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VEC;
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            ras_q <= ras_d;
        end
    end

    assign pc        = pc_q;
    assign ras_empty = empty_w;
    assign ras_full  = full_w;
    assign err       = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected PCs are queued at drive time and
// compared after the edge; a second build with a full-width imm covers PC wrap.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        en = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        br_taken = 1'b0;
    logic [15:0] imm = '0;
    logic [31:0] pc;
    logic        ras_empty, ras_full, err;

    logic        en_w = 1'b0;
    logic [2:0]  op_w = 3'd0;
    logic        br_taken_w = 1'b0;
    logic [31:0] imm_w = '0;
    logic [31:0] pc_w;
    logic        ras_empty_w, ras_full_w, err_w;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3, RET = 3'd4;

    pc_unit #(.ADDR_W(32), .IMM_W(16), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .br_taken(br_taken), .imm(imm),
        .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full), .err(err)
    );

    pc_unit #(.ADDR_W(32), .IMM_W(32), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en_w), .op(op_w), .br_taken(br_taken_w), .imm(imm_w),
        .pc(pc_w), .ras_empty(ras_empty_w), .ras_full(ras_full_w), .err(err_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare the oldest queued expectation against the sampled PC.
    task automatic pop_check(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic do_op(input string tag, input logic e, input logic [2:0] o,
                         input logic bt, input logic [15:0] im, input logic [31:0] exp_pc);
        @(negedge clk);
        en = e; op = o; br_taken = bt; imm = im;
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        pop_check(tag, pc);
        en = 1'b0;
    endtask

    task automatic do_op_w(input string tag, input logic [2:0] o, input logic bt,
                           input logic [31:0] im, input logic [31:0] exp_pc);
        @(negedge clk);
        en_w = 1'b1; op_w = o; br_taken_w = bt; imm_w = im;
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        pop_check(tag, pc_w);
        en_w = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 32'h100);
        check("reset_empty", {31'd0, ras_empty}, 32'd1);
        check("reset_full", {31'd0, ras_full}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("inc1", 1'b1, INC, 1'b0, 16'h0, 32'h101);
        do_op("inc2", 1'b1, INC, 1'b0, 16'h0, 32'h102);
        do_op("inc3", 1'b1, INC, 1'b0, 16'h0, 32'h103);
        do_op("hold1", 1'b0, JMP, 1'b1, 16'h55, 32'h103);
        do_op("hold2", 1'b0, CALL, 1'b1, 16'h77, 32'h103);
        check("hold_empty", {31'd0, ras_empty}, 32'd1);

        // Underflow then a push, so the mid-run reset has state to discard.
        do_op("ret_empty", 1'b1, RET, 1'b0, 16'h0, 32'h104);
        check("ret_empty_err", {31'd0, err}, 32'd1);
        do_op("call_pre_rst", 1'b1, CALL, 1'b0, 16'h40, 32'h40);
        check("call_pre_rst_empty", {31'd0, ras_empty}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h100);
        check("async_rst_empty", {31'd0, ras_empty}, 32'd1);
        check("async_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("jmp_20", 1'b1, JMP, 1'b0, 16'h20, 32'h20);
        do_op("br_neg", 1'b1, BR, 1'b1, 16'hFFFC, 32'h1C);
        do_op("br_nt", 1'b1, BR, 1'b0, 16'hFFFC, 32'h1D);
        do_op("br_pos", 1'b1, BR, 1'b1, 16'h0010, 32'h2D);
        do_op("op5_inc", 1'b1, 3'd5, 1'b1, 16'h1234, 32'h2E);
        do_op("op7_inc", 1'b1, 3'd7, 1'b1, 16'h1234, 32'h2F);
        do_op("jmp_zx", 1'b1, JMP, 1'b0, 16'h8000, 32'h0000_8000);

        do_op("jmp_10", 1'b1, JMP, 1'b0, 16'h10, 32'h10);
        do_op("call_100", 1'b1, CALL, 1'b0, 16'h100, 32'h100);
        do_op("call_200", 1'b1, CALL, 1'b0, 16'h200, 32'h200);
        do_op("ret_101", 1'b1, RET, 1'b0, 16'h0, 32'h101);
        do_op("ret_11", 1'b1, RET, 1'b0, 16'h0, 32'h11);
        check("nest_empty", {31'd0, ras_empty}, 32'd1);
        check("nest_err", {31'd0, err}, 32'd0);

        do_op("jmp_0", 1'b1, JMP, 1'b0, 16'h0, 32'h0);
        for (int i = 1; i <= 4; i++)
            do_op("ovf_call", 1'b1, CALL, 1'b0, 16'(i * 16), 32'(i * 16));
        check("four_full", {31'd0, ras_full}, 32'd1);
        check("four_err", {31'd0, err}, 32'd0);
        do_op("ovf_call5", 1'b1, CALL, 1'b0, 16'h50, 32'h50);
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_full", {31'd0, ras_full}, 32'd1);
        for (int i = 4; i >= 1; i--)
            do_op("ovf_ret", 1'b1, RET, 1'b0, 16'h0, 32'(i * 16 + 1));
        check("ovf_drain_empty", {31'd0, ras_empty}, 32'd1);
        check("ovf_drain_full", {31'd0, ras_full}, 32'd0);

        do_op("jmp_50", 1'b1, JMP, 1'b0, 16'h50, 32'h50);
        do_op("udf_ret", 1'b1, RET, 1'b0, 16'h0, 32'h51);
        check("udf_err", {31'd0, err}, 32'd1);
        check("udf_empty", {31'd0, ras_empty}, 32'd1);
        do_op("udf_inc", 1'b1, INC, 1'b0, 16'h0, 32'h52);
        check("err_sticky", {31'd0, err}, 32'd1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_clears_err", {31'd0, err}, 32'd0);
        check("rst_pc_again", pc, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-width imm build: wrap of increment and relative add.
        do_op_w("w_jmp_max", JMP, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op_w("w_inc_wrap", INC, 1'b0, 32'h0, 32'h0);
        check("w_wrap_err", {31'd0, err_w}, 32'd0);
        do_op_w("w_br_wrap", BR, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        do_op_w("w_br_fwd_wrap", BR, 1'b1, 32'h0000_0003, 32'h1);
        check("w_br_err", {31'd0, err_w}, 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised, clocked program-counter unit with an internal return-address stack (RAS). It replaces the combinational increment/branch counter in the fetch stage: it sequences instruction addresses and supports absolute jumps, PC-relative conditional branches, calls and returns. It is driven by the control unit and feeds the instruction-memory address.

## Interface

Parameters:
- ADDR_W, 32: PC width in bits.
- IMM_W, 16: width of `imm`. Must satisfy IMM_W <= ADDR_W.
- RESET_VEC, 0: PC value loaded on reset (ADDR_W bits).
- RAS_DEPTH, 4: return-stack entries. Must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance enable; 0 holds all state.
- op  in  3  0 INC, 1 JMP, 2 BR, 3 CALL, 4 RET; 5–7 behave as INC.
- br_taken  in  1  branch condition, used only when op=BR.
- imm  in  IMM_W  jump target or branch offset.
- pc  out  ADDR_W  current PC, registered.
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- err  out  1  sticky stack overflow/underflow flag.

## Operation

- Reset (rst_n=0, asynchronous):
  - pc=RESET_VEC, err=0.
  - Stack count=0, so ras_empty=1 and ras_full=0 (ras_full=1 after reset only if RAS_DEPTH=0, which is disallowed).
- en=0: pc, stack and err all hold. op, br_taken and imm are ignored.
- en=1, per op:
  - INC: pc <= pc+1.
  - JMP: pc <= zero-extended imm.
  - BR with br_taken=1: pc <= pc + sign-extended imm. With br_taken=0: pc <= pc+1.
  - CALL: push pc+1, then pc <= zero-extended imm.
  - RET: pop the top entry, then pc <= that entry.
- Arithmetic is modulo 2^ADDR_W. Increment and relative add wrap silently; a wrap is not an error.
- Stack structure:
  - LIFO implemented as a circular buffer: top pointer plus count (0..RAS_DEPTH).
  - Entries are ADDR_W wide.
- CALL with the stack full (overflow):
  - The jump still occurs.
  - The new return address overwrites the oldest entry (circular); count stays at RAS_DEPTH.
  - err <= 1.
- RET with the stack empty (underflow):
  - pc <= pc+1; stack unchanged; err <= 1.
- err is sticky and clears only on reset.
- ras_empty and ras_full are derived from the registered count. They reflect the state after the last edge.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Inputs are sampled at rising edge N; the new pc, flags and err are visible after edge N.
- Latency is 1 cycle for every op. One op can be issued per cycle, back-to-back.
- Consecutive CALL,RET: the RET pops the address pushed by the preceding CALL in the cycle before.
- Reset assertion mid-sequence:
  - Outputs go to reset values immediately, with no clock required.
  - Any push or pop in flight is discarded.
- Reset deassertion: the first update occurs at the first rising edge with rst_n=1 and en=1.

## Test plan

- Reset, hold, wrap (RESET_VEC=0x100):
  - Assert rst_n=0 mid-run -> pc=0x100, ras_empty=1, err=0 with no clock edge.
  - Release; 3 cycles INC en=1 -> pc 0x101, 0x102, 0x103.
  - en=0 for 2 cycles -> pc stays 0x103.
  - Force pc=0xFFFFFFFF via JMP (IMM_W=ADDR_W build); INC -> pc=0x0, err=0.
- Branch sign extension (pc=0x20, IMM_W=16):
  - BR, br_taken=1, imm=0xFFFC -> pc=0x1C.
  - BR, br_taken=0 -> pc=0x1D.
  - BR, br_taken=1, imm=0x0010 -> pc=0x2D.
- JMP zero extension: JMP imm=0x8000 -> pc=0x00008000 (not sign-extended).
- Nested call/return (RAS_DEPTH=4):
  - From pc=0x10: CALL 0x100; at 0x100 CALL 0x200; RET; RET.
  - Required pc sequence: 0x100, 0x200, 0x101, 0x11.
  - ras_empty=1 at end; err=0.
- Overflow (RAS_DEPTH=4):
  - 5 back-to-back CALLs from pc=0, 0x10, 0x20, 0x30, 0x40 -> err=1 after the 5th; ras_full=1.
  - 4 RETs then return 0x41, 0x31, 0x21, 0x11 (the oldest entry, 0x1, is lost); ras_empty=1.
- Underflow: RET on an empty stack at pc=0x50 -> pc=0x51, err=1, ras_empty=1. err stays 1 until rst_n=0.
